// File: rtl/rd_return_delayer_pkg.sv
// Shared types and sizing helpers for the DDR read-return delay line.
package rd_return_delayer_pkg;

   localparam int unsigned DEF_DATA_W        = 128;
   localparam int unsigned DEF_OUT_W         = 32;
   localparam int unsigned DEF_DEST_W        = 4;
   localparam int unsigned DEF_TS_W          = 16;
   localparam int unsigned DEF_DEPTH         = 64;
   localparam int unsigned DEF_DEFAULT_DELAY = 1000;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_e;

   function automatic int unsigned beats_of(input int unsigned data_w, input int unsigned out_w);
      return data_w / out_w;
   endfunction

   function automatic int unsigned ptr_w_of(input int unsigned depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

   function automatic int unsigned entry_w_of(input int unsigned ts_w, input int unsigned dest_w,
                                              input int unsigned data_w);
      return ts_w + dest_w + data_w;
   endfunction

endpackage

// File: rtl/rdd_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; also exposes the entry behind the head
// so the consumer can chain bursts without a bubble.
module rdd_sync_fifo
   import rd_return_delayer_pkg::*;
#(
   parameter int unsigned WIDTH = 148,
   parameter int unsigned DEPTH = 64
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   output logic [WIDTH-1:0] head_c_o,
   output logic [WIDTH-1:0] next_c_o,
   output logic             has_next_c_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned PTR_W = ptr_w_of(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic             full_q;
   logic             empty_q;
   logic             wr_ok;
   logic             rd_ok;

   assign wr_ok = wr_en_i & ~full_q;
   assign rd_ok = rd_en_i & ~empty_q;

   always_comb begin
      count_d = count_q;
      if (wr_ok && !rd_ok) begin
         count_d = count_q + CNT_W'(1);
      end else if (!wr_ok && rd_ok) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   // Storage is not reset; pointers alone decide what is valid.
   always_ff @(posedge clock) begin
      if (wr_ok) begin
         mem_q[wr_ptr_q] <= wr_data_i;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         if (wr_ok) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (rd_ok) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         count_q <= count_d;
         full_q  <= (count_d == CNT_W'(DEPTH));
         empty_q <= (count_d == '0);
      end
   end

   assign head_c_o     = mem_q[rd_ptr_q];
   assign next_c_o     = mem_q[rd_ptr_q + PTR_W'(1)];
   assign has_next_c_o = (count_q >= CNT_W'(2));
   assign full_o       = full_q;
   assign empty_o      = empty_q;

endmodule

// File: rtl/rd_return_delayer.sv
// Delay line for DDR read returns: timestamps each word, holds it until its age reaches
// the programmed delay, then replays it as OUT_W-wide beats under a valid/ack handshake.
module rd_return_delayer
   import rd_return_delayer_pkg::*;
#(
   parameter int unsigned DATA_W        = DEF_DATA_W,
   parameter int unsigned OUT_W         = DEF_OUT_W,
   parameter int unsigned DEST_W        = DEF_DEST_W,
   parameter int unsigned TS_W          = DEF_TS_W,
   parameter int unsigned DEPTH         = DEF_DEPTH,
   parameter int unsigned DEFAULT_DELAY = DEF_DEFAULT_DELAY
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [DATA_W-1:0] inData,
   input  logic [DEST_W-1:0] inDest,
   input  logic [TS_W-1:0]   cfgDelay,
   input  logic              cfgWr,
   output logic [OUT_W-1:0]  outData,
   output logic [DEST_W-1:0] outDest,
   output logic              outValid,
   output logic              outLast,
   input  logic              outAck,
   output logic              full,
   output logic [15:0]       dropCount
);

   localparam int unsigned BEATS   = beats_of(DATA_W, OUT_W);
   localparam int unsigned BIDX_W  = (BEATS <= 2) ? 1 : $clog2(BEATS);
   localparam int unsigned ENTRY_W = entry_w_of(TS_W, DEST_W, DATA_W);

   logic [TS_W-1:0]    counter_q;
   logic [TS_W-1:0]    delay_q;
   logic [15:0]        drop_q;
   state_e             state_q;
   logic [BIDX_W-1:0]  beat_q;
   logic               ripe_q;
   logic [OUT_W-1:0]   out_data_q;
   logic [DEST_W-1:0]  out_dest_q;
   logic               out_valid_q;
   logic               out_last_q;

   logic [ENTRY_W-1:0] head_c;
   logic [ENTRY_W-1:0] next_c;
   logic               has_next_c;
   logic               fifo_full;
   logic               fifo_empty;

   logic               enq_c;
   logic               push_c;
   logic               drop_c;
   logic [DATA_W-1:0]  head_data_c;
   logic [DEST_W-1:0]  head_dest_c;
   logic [TS_W-1:0]    head_age_c;
   logic               head_ripe_c;
   logic [DATA_W-1:0]  next_data_c;
   logic [DEST_W-1:0]  next_dest_c;
   logic [TS_W-1:0]    next_age_c;
   logic               next_ripe_c;
   logic               ack_c;
   logic               last_ack_c;
   logic [BIDX_W-1:0]  nb_c;

   rdd_sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock        (clock),
      .reset        (reset),
      .wr_en_i      (push_c),
      .wr_data_i    ({counter_q, inDest, inData}),
      .rd_en_i      (last_ack_c),
      .head_c_o     (head_c),
      .next_c_o     (next_c),
      .has_next_c_o (has_next_c),
      .full_o       (fifo_full),
      .empty_o      (fifo_empty)
   );

   assign enq_c  = (inDest != '0);
   assign push_c = enq_c & ~fifo_full;
   assign drop_c = enq_c & fifo_full;

   assign head_data_c = head_c[DATA_W-1:0];
   assign head_dest_c = head_c[DATA_W +: DEST_W];
   assign head_age_c  = counter_q - head_c[DATA_W+DEST_W +: TS_W];
   assign head_ripe_c = ~fifo_empty & (ripe_q | (head_age_c >= delay_q));

   // The entry behind the head is checked early so a ripe successor follows with no bubble.
   assign next_data_c = next_c[DATA_W-1:0];
   assign next_dest_c = next_c[DATA_W +: DEST_W];
   assign next_age_c  = counter_q - next_c[DATA_W+DEST_W +: TS_W];
   assign next_ripe_c = has_next_c & (next_age_c >= delay_q);

   assign ack_c      = out_valid_q & outAck;
   assign last_ack_c = ack_c & (beat_q == BIDX_W'(BEATS - 1));
   assign nb_c       = beat_q + BIDX_W'(1);

   always_ff @(posedge clock) begin
      if (reset) begin
         counter_q <= '0;
         delay_q   <= TS_W'(DEFAULT_DELAY);
         drop_q    <= '0;
      end else begin
         counter_q <= counter_q + TS_W'(1);
         if (cfgWr) begin
            delay_q <= cfgDelay;
         end
         if (drop_c && (drop_q != 16'hFFFF)) begin
            drop_q <= drop_q + 16'd1;
         end
      end
   end

   // Ripeness sticks to the current head so counter wrap cannot withdraw it.
   always_ff @(posedge clock) begin
      if (reset || last_ack_c) begin
         ripe_q <= 1'b0;
      end else if (head_ripe_c) begin
         ripe_q <= 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         beat_q      <= '0;
         out_data_q  <= '0;
         out_dest_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (head_ripe_c) begin
                  state_q     <= ST_SEND;
                  beat_q      <= '0;
                  out_data_q  <= head_data_c[OUT_W-1:0];
                  out_dest_q  <= head_dest_c;
                  out_valid_q <= 1'b1;
                  out_last_q  <= 1'b0;
               end
            end
            ST_SEND: begin
               if (ack_c) begin
                  if (!last_ack_c) begin
                     beat_q     <= nb_c;
                     out_data_q <= head_data_c[32'(nb_c)*OUT_W +: OUT_W];
                     out_last_q <= (nb_c == BIDX_W'(BEATS - 1));
                  end else if (next_ripe_c) begin
                     beat_q     <= '0;
                     out_data_q <= next_data_c[OUT_W-1:0];
                     out_dest_q <= next_dest_c;
                     out_last_q <= 1'b0;
                  end else begin
                     state_q     <= ST_IDLE;
                     beat_q      <= '0;
                     out_valid_q <= 1'b0;
                     out_last_q  <= 1'b0;
                  end
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               out_valid_q <= 1'b0;
               out_last_q  <= 1'b0;
            end
         endcase
      end
   end

   assign outData   = out_data_q;
   assign outDest   = out_dest_q;
   assign outValid  = out_valid_q;
   assign outLast   = out_last_q;
   assign full      = fifo_full;
   assign dropCount = drop_q;

endmodule

// File: tb/tb_rd_return_delayer.sv
// Scoreboard bench for rd_return_delayer: a word-level model predicts beats and release times.
module tb_rd_return_delayer;

   localparam int DATA_W = 128;
   localparam int OUT_W  = 32;
   localparam int DEST_W = 4;
   localparam int TS_W   = 16;
   localparam int DEPTH  = 64;
   localparam int BEATS  = DATA_W / OUT_W;

   logic              clock = 1'b0;
   logic              reset;
   logic [DATA_W-1:0] inData;
   logic [DEST_W-1:0] inDest;
   logic [TS_W-1:0]   cfgDelay;
   logic              cfgWr;
   logic [OUT_W-1:0]  outData;
   logic [DEST_W-1:0] outDest;
   logic              outValid;
   logic              outLast;
   logic              outAck;
   logic              full;
   logic [15:0]       dropCount;

   rd_return_delayer dut (
      .clock     (clock),
      .reset     (reset),
      .inData    (inData),
      .inDest    (inDest),
      .cfgDelay  (cfgDelay),
      .cfgWr     (cfgWr),
      .outData   (outData),
      .outDest   (outDest),
      .outValid  (outValid),
      .outLast   (outLast),
      .outAck    (outAck),
      .full      (full),
      .dropCount (dropCount)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      logic [DATA_W-1:0] data;
      logic [DEST_W-1:0] dest;
      int                t_acc;
      int                dly;
      bit                timed;
   } exp_t;

   exp_t exp_q[$];
   exp_t cur;
   int   checks = 0;
   int   errors = 0;
   int   pushed = 0;
   int   completed = 0;
   int   drops_m = 0;
   int   model_delay = 1000;
   int   bidx = 0;
   int   e_prev = -100000;
   int   rst_cyc = 0;
   bit   timing_mode = 1'b0;

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive_word(input logic [DATA_W-1:0] d, input logic [DEST_W-1:0] dst);
      inData = d;
      inDest = dst;
      if (dst != '0) begin
         check("full_flag", 64'(full), 64'((pushed - completed) == DEPTH));
         if ((pushed - completed) == DEPTH) begin
            drops_m = (drops_m == 65535) ? 65535 : drops_m + 1;
         end else begin
            exp_q.push_back('{data: d, dest: dst, t_acc: cyc, dly: model_delay, timed: timing_mode});
            pushed++;
         end
      end
   endtask

   task automatic send(input logic [DATA_W-1:0] d, input logic [DEST_W-1:0] dst);
      drive_word(d, dst);
      tick();
      inDest = '0;
   endtask

   task automatic cfg(input int v);
      cfgDelay    = TS_W'(v);
      cfgWr       = 1'b1;
      model_delay = v;
      tick();
      cfgWr = 1'b0;
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      inDest = '0;
      cfgWr  = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      exp_q.delete();
      bidx        = 0;
      pushed      = 0;
      completed   = 0;
      drops_m     = 0;
      model_delay = 1000;
      rst_cyc     = cyc;
   endtask

   task automatic wait_drain(input int bound);
      int n = 0;
      while (exp_q.size() != 0 && n < bound) begin
         tick();
         n++;
      end
      check("drain", 64'(exp_q.size()), 64'd0);
   endtask

   function automatic logic [DATA_W-1:0] rand_word();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Monitor: every presented beat is compared with the model's next expected beat.
   logic [OUT_W-1:0]  held_data;
   logic [DEST_W-1:0] held_dest;
   logic              held_last;
   bit                held = 1'b0;
   logic [OUT_W-1:0]  exp_data;

   always @(negedge clock) begin
      if (reset) begin
         held = 1'b0;
      end else begin
         if (held) begin
            check("hold", {outValid, outLast, outDest, outData}, {1'b1, held_last, held_dest, held_data});
         end
         held = 1'b0;
         if (exp_q.size() == 0) begin
            check("idle_valid", 64'(outValid), 64'd0);
         end else if (outValid && outAck) begin
            cur      = exp_q[0];
            exp_data = cur.data[bidx*OUT_W +: OUT_W];
            check("beat", {outLast, outDest, outData}, {(bidx == BEATS - 1), cur.dest, exp_data});
            if (bidx == 0 && cur.timed) begin
               check("start_cycle", 64'(cyc), 64'(imax(cur.t_acc + imax(cur.dly, 1), e_prev) + 1));
            end
            if (bidx == BEATS - 1) begin
               void'(exp_q.pop_front());
               bidx = 0;
               completed++;
               e_prev = cyc;
            end else begin
               bidx++;
            end
         end else if (outValid) begin
            held      = 1'b1;
            held_data = outData;
            held_dest = outDest;
            held_last = outLast;
         end
      end
   end

   initial begin
      int c;
      int vcyc;
      bit found;
      reset    = 1'b1;
      inData   = '0;
      inDest   = '0;
      cfgDelay = '0;
      cfgWr    = 1'b0;
      outAck   = 1'b0;
      do_reset();

      check("rst_valid", 64'(outValid), 64'd0);
      check("rst_last", 64'(outLast), 64'd0);
      check("rst_data", 64'(outData), 64'd0);
      check("rst_dest", 64'(outDest), 64'd0);
      check("rst_full", 64'(full), 64'd0);
      check("rst_drop", 64'(dropCount), 64'd0);

      // Single word, delay 10
      outAck = 1'b1;
      timing_mode = 1'b1;
      cfg(10);
      send(128'h00000044_00000033_00000022_00000011, 4'd3);
      wait_drain(100);

      // Back-to-back words, delay 4
      cfg(4);
      send(rand_word(), 4'd5);
      send(rand_word(), 4'd9);
      wait_drain(100);

      // Delay lowered while a word waits
      timing_mode = 1'b0;
      cfg(1000);
      send(rand_word(), 4'd6);
      repeat (49) tick();
      c        = cyc;
      cfgDelay = 16'd2;
      cfgWr    = 1'b1;
      model_delay = 2;
      tick();
      cfgWr = 1'b0;
      found = 1'b0;
      vcyc  = -1;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clock);
         if (outValid) begin
            found = 1'b1;
            vcyc  = cyc;
         end
      end
      check("cfg_release", 64'(vcyc), 64'(c + 2));
      wait_drain(50);
      timing_mode = 1'b1;
      cfg(0);
      send(rand_word(), 4'd7);
      wait_drain(50);

      // Release across counter wrap
      cfg(32);
      while ((cyc - rst_cyc) != 32'hFFF0) tick();
      send(rand_word(), 4'd2);
      wait_drain(100);

      // Overflow with a stalled consumer
      timing_mode = 1'b0;
      outAck = 1'b0;
      cfg(5);
      for (int i = 0; i < DEPTH; i++) send(rand_word(), 4'($urandom_range(1, 15)));
      check("full_set", 64'(full), 64'd1);
      for (int i = 0; i < 3; i++) send(rand_word(), 4'($urandom_range(1, 15)));
      check("drop_count", 64'(dropCount), 64'd3);
      outAck = 1'b1;
      wait_drain(DEPTH * BEATS + 200);
      check("full_clear", 64'(full), 64'd0);

      // Randomized traffic with random ack and delay changes
      for (int i = 0; i < 2000; i++) begin
         outAck = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 99) < 30) drive_word(rand_word(), 4'($urandom_range(0, 15)));
         if ($urandom_range(0, 99) < 2) begin
            cfgDelay    = TS_W'($urandom_range(0, 20));
            cfgWr       = 1'b1;
            model_delay = int'(cfgDelay);
         end
         tick();
         inDest = '0;
         cfgWr  = 1'b0;
      end
      outAck = 1'b1;
      wait_drain(DEPTH * BEATS * 4 + 500);
      check("rand_drop", 64'(dropCount), 64'(drops_m));

      // Ack toggling mid-burst, then reset mid-burst
      cfg(2);
      send(rand_word(), 4'd4);
      send(rand_word(), 4'd8);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         if (outValid) found = 1'b1;
      end
      check("burst_start", 64'(found), 64'd1);
      for (int i = 0; i < 4; i++) begin
         outAck = (i % 2 == 0);
         tick();
      end
      outAck = 1'b0;
      do_reset();
      check("mid_rst_valid", 64'(outValid), 64'd0);
      check("mid_rst_full", 64'(full), 64'd0);
      check("mid_rst_drop", 64'(dropCount), 64'd0);
      outAck = 1'b1;
      repeat (1100) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
